// File: rtl/pe_layer_resolver.sv
// Two-stage layer priority resolver: S1 captures the candidate layers, S2 picks
// the frontmost opaque layer and its runner-up, with a valid/ready handshake and a pixel counter.
module pe_layer_resolver #(
  parameter int LAYERS = 5,
  parameter int PRIO_W = 2,
  parameter int DATA_W = 15,
  parameter int CNT_W  = 8,
  parameter int ID_W   = $clog2(LAYERS + 1)
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LAYERS*PRIO_W-1:0] in_prio,
  input  logic [LAYERS-1:0]        in_opaque,
  input  logic [LAYERS*DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0]        backdrop,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ID_W-1:0]          top_id,
  output logic [DATA_W-1:0]        top_data,
  output logic [ID_W-1:0]          second_id,
  output logic [DATA_W-1:0]        second_data,
  output logic [CNT_W-1:0]         pix_count
);

  logic                     s1_valid_q, s1_valid_d;
  logic [LAYERS*PRIO_W-1:0] s1_prio_q, s1_prio_d;
  logic [LAYERS-1:0]        s1_opaque_q, s1_opaque_d;
  logic [LAYERS*DATA_W-1:0] s1_data_q, s1_data_d;
  logic [DATA_W-1:0]        s1_backdrop_q, s1_backdrop_d;

  logic                     out_valid_q, out_valid_d;
  logic [ID_W-1:0]          top_id_q, top_id_d, second_id_q, second_id_d;
  logic [DATA_W-1:0]        top_data_q, top_data_d, second_data_q, second_data_d;
  logic [CNT_W-1:0]         pix_count_q, pix_count_d;

  logic s1_en, s2_en;

  logic [PRIO_W-1:0] prio_arr [LAYERS];
  logic [DATA_W-1:0] data_arr [LAYERS];

  genvar gi;
  generate
    for (gi = 0; gi < LAYERS; gi++) begin : g_unpack
      assign prio_arr[gi] = s1_prio_q[gi*PRIO_W +: PRIO_W];
      assign data_arr[gi] = s1_data_q[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign s2_en    = !out_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en;

  // Linear scan in ascending index: a strict '<' on priority lets the lower index win ties.
  logic              t_found, s_found;
  logic [ID_W-1:0]   t_idx, s_idx;
  logic [PRIO_W-1:0] t_prio, s_prio;
  logic [DATA_W-1:0] t_data, s_data;

  always_comb begin
    t_found = 1'b0;
    t_idx   = ID_W'(LAYERS);
    t_prio  = '0;
    t_data  = s1_backdrop_q;
    s_found = 1'b0;
    s_idx   = ID_W'(LAYERS);
    s_prio  = '0;
    s_data  = s1_backdrop_q;
    for (int i = 0; i < LAYERS; i++) begin
      if (s1_opaque_q[i]) begin
        if (!t_found || prio_arr[i] < t_prio) begin
          s_found = t_found;
          s_idx   = t_idx;
          s_prio  = t_prio;
          s_data  = t_data;
          t_found = 1'b1;
          t_idx   = ID_W'(i);
          t_prio  = prio_arr[i];
          t_data  = data_arr[i];
        end else if (!s_found || prio_arr[i] < s_prio) begin
          s_found = 1'b1;
          s_idx   = ID_W'(i);
          s_prio  = prio_arr[i];
          s_data  = data_arr[i];
        end
      end
    end
  end

  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_prio_d     = s1_prio_q;
    s1_opaque_d   = s1_opaque_q;
    s1_data_d     = s1_data_q;
    s1_backdrop_d = s1_backdrop_q;
    out_valid_d   = out_valid_q;
    top_id_d      = top_id_q;
    top_data_d    = top_data_q;
    second_id_d   = second_id_q;
    second_data_d = second_data_q;
    pix_count_d   = pix_count_q;
    if (clear) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
      pix_count_d = '0;
    end else begin
      if (s1_en) begin
        s1_valid_d = in_valid;
        if (in_valid) begin
          s1_prio_d     = in_prio;
          s1_opaque_d   = in_opaque;
          s1_data_d     = in_data;
          s1_backdrop_d = backdrop;
        end
      end
      if (s2_en) begin
        out_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          top_id_d      = t_idx;
          top_data_d    = t_data;
          second_id_d   = s_idx;
          second_data_d = s_data;
        end
      end
      if (out_valid_q && out_ready) pix_count_d = pix_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      s1_valid_q    <= 1'b0;
      s1_prio_q     <= '0;
      s1_opaque_q   <= '0;
      s1_data_q     <= '0;
      s1_backdrop_q <= '0;
      out_valid_q   <= 1'b0;
      top_id_q      <= '0;
      top_data_q    <= '0;
      second_id_q   <= '0;
      second_data_q <= '0;
      pix_count_q   <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_prio_q     <= s1_prio_d;
      s1_opaque_q   <= s1_opaque_d;
      s1_data_q     <= s1_data_d;
      s1_backdrop_q <= s1_backdrop_d;
      out_valid_q   <= out_valid_d;
      top_id_q      <= top_id_d;
      top_data_q    <= top_data_d;
      second_id_q   <= second_id_d;
      second_data_q <= second_data_d;
      pix_count_q   <= pix_count_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign top_id      = top_id_q;
  assign top_data    = top_data_q;
  assign second_id   = second_id_q;
  assign second_data = second_data_q;
  assign pix_count   = pix_count_q;

endmodule

// File: tb/tb_pe_layer_resolver.sv
// Bench for pe_layer_resolver: directed vectors, random traffic against a
// key-ordering reference model, backpressure, counter wrap, clear and async reset.
module tb_pe_layer_resolver;
  localparam int L  = 5;
  localparam int PW = 2;
  localparam int DW = 15;
  localparam int CW = 8;
  localparam int IW = 3;

  logic            clk, rst_b, clear, in_valid, in_ready, out_valid, out_ready;
  logic [L*PW-1:0] in_prio;
  logic [L-1:0]    in_opaque;
  logic [L*DW-1:0] in_data;
  logic [DW-1:0]   backdrop, top_data, second_data;
  logic [IW-1:0]   top_id, second_id;
  logic [CW-1:0]   pix_count;

  pe_layer_resolver #(.LAYERS(L), .PRIO_W(PW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_b(rst_b), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_prio(in_prio), .in_opaque(in_opaque), .in_data(in_data), .backdrop(backdrop),
    .out_valid(out_valid), .out_ready(out_ready),
    .top_id(top_id), .top_data(top_data), .second_id(second_id), .second_data(second_data),
    .pix_count(pix_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] tid;
    logic [DW-1:0] td;
    logic [IW-1:0] sid;
    logic [DW-1:0] sd;
  } res_t;

  typedef struct {
    logic [L*PW-1:0] prio;
    logic [L-1:0]    opq;
    logic [DW-1:0]   bd;
    logic [IW-1:0]   tid;
    logic [DW-1:0]   td;
    logic [IW-1:0]   sid;
    logic [DW-1:0]   sd;
  } vec_t;

  res_t          q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [CW-1:0] exp_cnt = '0;

  // Reference: rank opaque layers by key prio*L+index, take the two smallest.
  function automatic res_t ref_model(logic [L*PW-1:0] p, logic [L-1:0] o,
                                     logic [L*DW-1:0] d, logic [DW-1:0] bd);
    res_t r;
    int   best = -1;
    int   nxt  = -1;
    for (int i = 0; i < L; i++)
      if (o[i] && (best < 0 || int'(p[i*PW +: PW]) * L + i < int'(p[best*PW +: PW]) * L + best))
        best = i;
    for (int i = 0; i < L; i++)
      if (o[i] && i != best && (nxt < 0 || int'(p[i*PW +: PW]) * L + i < int'(p[nxt*PW +: PW]) * L + nxt))
        nxt = i;
    r.tid = (best < 0) ? IW'(L) : IW'(best);
    r.td  = (best < 0) ? bd : d[best*DW +: DW];
    r.sid = (nxt < 0) ? IW'(L) : IW'(nxt);
    r.sd  = (nxt < 0) ? bd : d[nxt*DW +: DW];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Entered just after a falling edge with inputs driven; samples before the rising edge.
  task automatic tick(output bit acc);
    bit   xfr;
    res_t e;
    #3;
    acc = in_valid && in_ready;
    xfr = out_valid && out_ready;
    chk("in_ready", in_ready, !(q.size() == 2 && !out_ready));
    chk("pix_count", pix_count, exp_cnt);
    if (q.size() == 0) chk("out_valid_idle", out_valid, 0);
    if (clear) begin
      q.delete();
      exp_cnt = '0;
    end else begin
      if (xfr && q.size() > 0) begin
        e = q.pop_front();
        chk("top_id", top_id, e.tid);
        chk("top_data", top_data, e.td);
        chk("second_id", second_id, e.sid);
        chk("second_data", second_data, e.sd);
        exp_cnt++;
      end
      if (acc) q.push_back(ref_model(in_prio, in_opaque, in_data, backdrop));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_pixel();
    in_prio   = L*PW'($urandom);
    in_opaque = L'($urandom);
    backdrop  = DW'($urandom);
    for (int i = 0; i < L; i++) in_data[i*DW +: DW] = DW'($urandom);
  endtask

  task automatic drain();
    bit a;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick(a);
  endtask

  task automatic fill_both();
    bit a;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rand_pixel();
    tick(a);
    rand_pixel();
    tick(a);
    in_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[5];
    bit   a;
    int   sent;
    int   guard;
    logic [L*DW-1:0] seq_data;

    for (int i = 0; i < L; i++) seq_data[i*DW +: DW] = DW'(16'h100 + i);
    vt[0] = '{{2'd0, 2'd1, 2'd1, 2'd2, 2'd3}, 5'b11111, 15'h7FFF, 3'd4, 15'h104, 3'd2, 15'h102};
    vt[1] = '{{5{2'd2}},                      5'b11111, 15'h7FFF, 3'd0, 15'h100, 3'd1, 15'h101};
    vt[2] = '{{5{2'd0}},                      5'b01000, 15'h7FFF, 3'd3, 15'h103, 3'd5, 15'h7FFF};
    vt[3] = '{{5{2'd1}},                      5'b00000, 15'h7FFF, 3'd5, 15'h7FFF, 3'd5, 15'h7FFF};
    vt[4] = '{{2'd0, 2'd3, 2'd2, 2'd0, 2'd1}, 5'b10010, 15'h1234, 3'd1, 15'h101, 3'd4, 15'h104};

    rst_b = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_prio = '0; in_opaque = '0; in_data = '0; backdrop = '0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pix_count", pix_count, 0);
    chk("rst_top_id", top_id, 0);
    chk("rst_top_data", top_data, 0);
    chk("rst_second_id", second_id, 0);
    chk("rst_second_data", second_data, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_b = 1'b1;

    // Directed vectors, each through an empty pipe to observe latency.
    for (int v = 0; v < 5; v++) begin
      in_prio = vt[v].prio; in_opaque = vt[v].opq; in_data = seq_data; backdrop = vt[v].bd;
      in_valid = 1'b1; out_ready = 1'b1;
      tick(a);
      in_valid = 1'b0;
      chk("latency_cycle1", out_valid, 0);
      tick(a);
      chk("latency_cycle2", out_valid, 1);
      chk("vec_top_id", top_id, vt[v].tid);
      chk("vec_top_data", top_data, vt[v].td);
      chk("vec_second_id", second_id, vt[v].sid);
      chk("vec_second_data", second_data, vt[v].sd);
      tick(a);
    end

    // Random traffic with random stalls.
    for (int n = 0; n < 300; n++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 1) == 1;
      rand_pixel();
      tick(a);
    end
    drain();

    // Backpressure: 10 pixels from zero count, 50% out_ready.
    clear = 1'b1; in_valid = 1'b0; tick(a); clear = 1'b0;
    sent = 0; guard = 0;
    while ((sent < 10 || q.size() > 0) && guard < 200) begin
      in_valid  = sent < 10;
      out_ready = $urandom_range(0, 1) == 1;
      rand_pixel();
      tick(a);
      if (a) sent++;
      guard++;
    end
    chk("bp_completed", guard < 200, 1);
    chk("bp_pix_count", pix_count, 10);

    // Counter wrap after 257 transfers.
    clear = 1'b1; in_valid = 1'b0; tick(a); clear = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int n = 0; n < 257; n++) begin
      rand_pixel();
      tick(a);
    end
    drain();
    chk("wrap_pix_count", pix_count, 1);

    // Clear with both stages full and out_ready high: everything is discarded.
    fill_both();
    chk("clear_setup_valid", out_valid, 1);
    clear = 1'b1; out_ready = 1'b1; in_valid = 1'b1; rand_pixel();
    tick(a);
    clear = 1'b0; in_valid = 1'b0;
    chk("clear_out_valid", out_valid, 0);
    chk("clear_pix_count", pix_count, 0);
    drain();

    // Async reset between edges with both stages full.
    fill_both();
    in_valid = 1'b1;
    #2 rst_b = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_pix_count", pix_count, 0);
    chk("arst_top_id", top_id, 0);
    chk("arst_second_data", second_data, 0);
    chk("arst_in_ready", in_ready, 1);
    q.delete();
    exp_cnt = '0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1; rand_pixel();
    tick(a);
    in_valid = 1'b0;
    chk("post_rst_cycle1", out_valid, 0);
    tick(a);
    chk("post_rst_cycle2", out_valid, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
